// File: rtl/code_sender_pkg.sv
// Shared definitions for the code sender block.
//   state_t        : sequencer states
//   DEF_*          : default parameter values used by code_sender and tick_gen
//   digit_at()     : picks one 4-bit digit out of the 16-bit code, MSD first
//   max3()         : largest of three ints, used to size the tick-phase counter
package code_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    GAP,
    SEND,
    WAIT_RESP,
    DONE
  } state_t;

  localparam int DEF_TICK_DIV   = 50_000_000;
  localparam int DEF_HOLD_TICKS = 1;
  localparam int DEF_GAP_TICKS  = 1;
  localparam int DEF_RESP_TICKS = 4;

  // Index 0 is the first digit on the wire, which is code[15:12].
  function automatic logic [3:0] digit_at(input logic [15:0] code, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = code[15:12];
      2'd1:    d = code[11:8];
      2'd2:    d = code[7:4];
      default: d = code[3:0];
    endcase
    return d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_sender_if.sv
// Handshake bundle between a code sender and its surroundings.
//   start, code            : request side, one-cycle start with the 16-bit code
//   result_ok, result_bad  : verdict lines from the external checker
//   digit, enable          : digit bus and active-low submit strobe to the checker
//   busy, done             : transfer status, done is a one-cycle pulse
//   pass, fail, timeout    : sticky verdict flags
// master: the side that requests transfers and supplies checker verdicts.
// slave : the code sender itself.
interface code_sender_if;
  logic        start;
  logic [15:0] code;
  logic        result_ok;
  logic        result_bad;
  logic [3:0]  digit;
  logic        enable;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;

  modport master (
    output start, code, result_ok, result_bad,
    input  digit, enable, busy, done, pass, fail, timeout
  );

  modport slave (
    input  start, code, result_ok, result_bad,
    output digit, enable, busy, done, pass, fail, timeout
  );
endinterface

// File: rtl/code_sender_tick_gen.sv
// Tick prescaler: emits a one-cycle tick every TICK_DIV clk cycles.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear, restarts the count so the next tick is TICK_DIV
//          cycles after the clearing edge
//   tick : high for one clk once per period
module tick_gen
  import code_sender_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/code_sender.sv
// Code sender: clocks a 4-digit code into an external checker as a wake strobe
// followed by four digit strobes, then waits for the checker's verdict.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : code_sender_if.slave (start/code in, checker results in,
//          digit/enable strobe out, busy/done/pass/fail/timeout out)
// All sequencing advances on the prescaler tick; only start capture and result
// sampling happen on every clk.
module code_sender
  import code_sender_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int RESP_TICKS = DEF_RESP_TICKS
) (
  input  logic          clk,
  input  logic          rst,
  code_sender_if.slave  bus
);

  localparam int TMAX = max3(HOLD_TICKS, GAP_TICKS, RESP_TICKS);
  localparam int TCW  = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  localparam logic [TCW-1:0] HOLD_LAST = TCW'(HOLD_TICKS - 1);
  localparam logic [TCW-1:0] GAP_LAST  = TCW'(GAP_TICKS - 1);
  localparam logic [TCW-1:0] RESP_LAST = TCW'(RESP_TICKS - 1);
  localparam logic [TCW-1:0] GAP_DONE  = TCW'(GAP_TICKS);

  state_t          state_q, state_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;     // ticks spent in the current phase
  logic [1:0]      idx_q, idx_d;       // next digit to send, wraps after 4th
  logic            sent_q, sent_d;     // all four digits have gone out
  logic [15:0]     code_q, code_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            timeout_q, timeout_d;

  logic            tick;
  logic            tick_clr;
  logic            enable_c;
  logic [3:0]      digit_c;
  logic            busy_c;
  logic            done_c;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      idx_q     <= '0;
      sent_q    <= 1'b0;
      code_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      idx_q     <= idx_d;
      sent_q    <= sent_d;
      code_q    <= code_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    sent_d    = sent_q;
    code_d    = code_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    tick_clr  = 1'b0;
    enable_c  = 1'b1;
    digit_c   = 4'd0;
    busy_c    = 1'b1;
    done_c    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          code_d    = bus.code;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          tcnt_d    = '0;
          idx_d     = '0;
          sent_d    = 1'b0;
          tick_clr  = 1'b1;
          state_d   = WAKE;
        end
      end

      WAKE: begin
        enable_c = 1'b0;
        if (tick) begin
          if (tcnt_q == HOLD_LAST) begin
            tcnt_d  = '0;
            state_d = GAP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      GAP: begin
        // Pre-present the upcoming digit so it is settled before enable falls.
        digit_c = sent_q ? 4'd0 : digit_at(code_q, idx_q);
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            if (sent_q) begin
              // The response window is measured from the end of the last
              // strobe, so the final gap already counts toward it.
              tcnt_d  = GAP_DONE;
              state_d = WAIT_RESP;
            end else begin
              tcnt_d  = '0;
              state_d = SEND;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      SEND: begin
        enable_c = 1'b0;
        digit_c  = digit_at(code_q, idx_q);
        if (tick) begin
          if (tcnt_q == HOLD_LAST) begin
            tcnt_d  = '0;
            idx_d   = idx_q + 2'd1;
            sent_d  = sent_q | (idx_q == 2'd3);
            state_d = GAP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      WAIT_RESP: begin
        // Results are checked every clk; bad wins over ok when both appear.
        if (bus.result_bad) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (bus.result_ok) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else if (tick) begin
          if (tcnt_q >= RESP_LAST) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.enable  = enable_c;
  assign bus.digit   = digit_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_code_sender.sv
module tb_code_sender;

  logic clk;
  logic rst;

  code_sender_if bus ();

  code_sender #(
    .TICK_DIV   (4),
    .HOLD_TICKS (1),
    .GAP_TICKS  (1),
    .RESP_TICKS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Strobe monitor state
  int         cyc        = 0;
  int         strobe_cnt = 0;
  int         done_cnt   = 0;
  int         unstable   = 0;
  int         end_cyc    = 0;
  int         to_cyc     = 0;
  logic       in_lo      = 1'b0;
  int         lo_len     = 0;
  logic [3:0] lo_dig     = 4'd0;
  logic       prev_en    = 1'b1;
  logic [3:0] prev_dig   = 4'd0;
  logic       to_prev    = 1'b0;
  logic [3:0] s_dig [64];
  int         s_len [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_en  <= bus.enable;
    prev_dig <= bus.digit;
    if (bus.enable === 1'b0) begin
      if (in_lo) begin
        lo_len <= lo_len + 1;
        if (bus.digit !== lo_dig) unstable <= unstable + 1;
      end else begin
        in_lo  <= 1'b1;
        lo_len <= 1;
        lo_dig <= bus.digit;
        if (prev_en && (prev_dig !== bus.digit)) unstable <= unstable + 1;
      end
    end else if (in_lo) begin
      in_lo                 <= 1'b0;
      s_dig[strobe_cnt % 64] <= lo_dig;
      s_len[strobe_cnt % 64] <= lo_len;
      strobe_cnt            <= strobe_cnt + 1;
      end_cyc               <= cyc;
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if ((bus.timeout === 1'b1) && !to_prev) to_cyc <= cyc;
    to_prev <= bus.timeout;
  end

  task automatic pulse_start(input logic [15:0] c);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.code  = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.code  = 16'h0000;
  endtask

  // Checker model: waits for wake + 4 digit strobes, then answers inside the
  // response window. mode 0: verdict from the secret 2,0,1,4; 1: silent;
  // 2: both results high together.
  task automatic respond(input int b, input int mode, output bit seen);
    bit good;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (strobe_cnt - b >= 5) seen = 1'b1;
    end
    if (seen && mode != 1) begin
      good = (s_dig[(b+1)%64] == 4'd2) && (s_dig[(b+2)%64] == 4'd0) &&
             (s_dig[(b+3)%64] == 4'd1) && (s_dig[(b+4)%64] == 4'd4);
      repeat (6) @(posedge clk);
      #1;
      if (mode == 2) begin
        bus.result_ok  = 1'b1;
        bus.result_bad = 1'b1;
      end else begin
        bus.result_ok  = good;
        bus.result_bad = !good;
      end
      @(posedge clk); #1;
      bus.result_ok  = 1'b0;
      bus.result_bad = 1'b0;
    end
  endtask

  task automatic wait_done(input int db, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt != db) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    checks++; if (bus.enable !== 1'b1) begin failures++; $display("FAIL rst_enable: got %b want 1", bus.enable); end
    checks++; if (bus.digit !== 4'd0) begin failures++; $display("FAIL rst_digit: got %0h want 0", bus.digit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if ({bus.pass, bus.fail, bus.timeout} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b want 000", {bus.pass, bus.fail, bus.timeout}); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.enable !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL idle_after_rst: got enable=%b busy=%b want 1 0", bus.enable, bus.busy); end
  endtask

  task automatic test_happy;
    int b, db, ub;
    bit seen, ok;
    logic [3:0] exp_d [5];
    exp_d[0] = 4'd0; exp_d[1] = 4'd2; exp_d[2] = 4'd0; exp_d[3] = 4'd1; exp_d[4] = 4'd4;
    b = strobe_cnt; db = done_cnt; ub = unstable;
    pulse_start(16'h2014);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL happy_busy: got %b want 1", bus.busy); end
    respond(b, 0, seen);
    wait_done(db, ok);
    checks++; if (!(seen && ok)) begin failures++; $display("FAIL happy_wait: got seen=%b done=%b want 1 1", seen, ok); end
    checks++; if (strobe_cnt - b !== 5) begin failures++; $display("FAIL happy_strobes: got %0d want 5", strobe_cnt - b); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_dig[(b+i)%64] !== exp_d[i]) begin failures++; $display("FAIL happy_digit%0d: got %0h want %0h", i, s_dig[(b+i)%64], exp_d[i]); end
      checks++; if (s_len[(b+i)%64] !== 4) begin failures++; $display("FAIL happy_len%0d: got %0d want 4", i, s_len[(b+i)%64]); end
    end
    checks++; if (unstable - ub !== 0) begin failures++; $display("FAIL happy_digit_stable: got %0d changes want 0", unstable - ub); end
    @(negedge clk); #1;
    checks++; if ({bus.pass, bus.fail, bus.timeout} !== 3'b100) begin failures++; $display("FAIL happy_flags: got %b want 100", {bus.pass, bus.fail, bus.timeout}); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL happy_done_pulses: got %0d want 1", done_cnt - db); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL happy_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_wrong_code;
    int b, db;
    bit seen, ok;
    b = strobe_cnt; db = done_cnt;
    pulse_start(16'h2015);
    respond(b, 0, seen);
    wait_done(db, ok);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (!(seen && ok)) begin failures++; $display("FAIL wrong_wait: got seen=%b done=%b want 1 1", seen, ok); end
    checks++; if (s_dig[(b+4)%64] !== 4'd5) begin failures++; $display("FAIL wrong_last_digit: got %0h want 5", s_dig[(b+4)%64]); end
    checks++; if ({bus.pass, bus.fail, bus.timeout} !== 3'b010) begin failures++; $display("FAIL wrong_flags: got %b want 010", {bus.pass, bus.fail, bus.timeout}); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL wrong_done_pulses: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_timeout;
    int b, db;
    bit seen, ok;
    b = strobe_cnt; db = done_cnt;
    pulse_start(16'h2014);
    respond(b, 1, seen);
    wait_done(db, ok);
    checks++; if (!(seen && ok)) begin failures++; $display("FAIL timeout_wait: got seen=%b done=%b want 1 1", seen, ok); end
    checks++; if (to_cyc - end_cyc !== 16) begin failures++; $display("FAIL timeout_latency: got %0d clk want 16", to_cyc - end_cyc); end
    checks++; if ({bus.pass, bus.fail, bus.timeout} !== 3'b001) begin failures++; $display("FAIL timeout_flags: got %b want 001", {bus.pass, bus.fail, bus.timeout}); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL timeout_done_pulses: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_both_results;
    int b, db;
    bit seen, ok;
    b = strobe_cnt; db = done_cnt;
    pulse_start(16'h2014);
    respond(b, 2, seen);
    wait_done(db, ok);
    #1;
    checks++; if (!(seen && ok)) begin failures++; $display("FAIL both_wait: got seen=%b done=%b want 1 1", seen, ok); end
    checks++; if ({bus.pass, bus.fail, bus.timeout} !== 3'b010) begin failures++; $display("FAIL both_flags: got %b want 010", {bus.pass, bus.fail, bus.timeout}); end
  endtask

  task automatic test_start_while_busy;
    int b, db;
    bit found, seen, ok;
    b = strobe_cnt; db = done_cnt;
    pulse_start(16'h2014);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.enable === 1'b0 && bus.digit === 4'd2 && strobe_cnt - b == 1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL busy_find_digit2: got none want strobe of 2"); end
    pulse_start(16'h9999);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_restart_busy: got %b want 1", bus.busy); end
    respond(b, 0, seen);
    wait_done(db, ok);
    #1;
    checks++; if (!(seen && ok)) begin failures++; $display("FAIL busy_wait: got seen=%b done=%b want 1 1", seen, ok); end
    checks++; if ({s_dig[(b+2)%64], s_dig[(b+3)%64], s_dig[(b+4)%64]} !== 12'h014) begin failures++; $display("FAIL busy_digits: got %h want 014", {s_dig[(b+2)%64], s_dig[(b+3)%64], s_dig[(b+4)%64]}); end
    checks++; if (strobe_cnt - b !== 5) begin failures++; $display("FAIL busy_strobes: got %0d want 5", strobe_cnt - b); end
    checks++; if (bus.pass !== 1'b1) begin failures++; $display("FAIL busy_pass: got %b want 1", bus.pass); end
  endtask

  task automatic test_reset_mid;
    int b, db, sb;
    bit found;
    b = strobe_cnt; db = done_cnt;
    pulse_start(16'h2014);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.enable === 1'b0 && bus.digit === 4'd2 && strobe_cnt - b == 1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_find_digit: got none want strobe of 2"); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.enable !== 1'b1) begin failures++; $display("FAIL rmid_enable: got %b want 1", bus.enable); end
    checks++; if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b00000) begin failures++; $display("FAIL rmid_flags: got %b want 00000", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout}); end
    checks++; if (bus.digit !== 4'd0) begin failures++; $display("FAIL rmid_digit: got %0h want 0", bus.digit); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    sb = strobe_cnt;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (strobe_cnt !== sb) begin failures++; $display("FAIL rmid_no_strobes: got %0d want %0d", strobe_cnt, sb); end
    checks++; if (done_cnt !== db) begin failures++; $display("FAIL rmid_no_done: got %0d want %0d", done_cnt, db); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_idle: got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.code       = 16'h0000;
    bus.result_ok  = 1'b0;
    bus.result_bad = 1'b0;
    test_reset();
    test_happy();
    test_wrong_code();
    test_timeout();
    test_both_results();
    test_start_while_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
